if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the WISC-S15 pipeline. It sits directly upstream of the control decoder.
- Owns the PC and runs a ready/valid-style handshake with a multi-cycle instruction memory.
- Holds the IF/ID pipeline register whose opcode field drives the control decoder.
- Handles hazard stalls, branch/call/ret redirects and halt on opcode 4'b1111.

Parameters:
- PC_W, 16, PC and instruction-address width (word addressed).
- INSTR_W, 16, instruction width; opcode is the top 4 bits.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard unit: hold IF/ID contents
- redirect  input  1  taken branch/CALL/RET resolved downstream
- redirect_pc  input  PC_W  target PC for redirect
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  PC_W  fetch address, equals pc
- imem_rdy  input  1  imem_data valid this cycle
- imem_data  input  INSTR_W  fetched instruction
- ifid_valid  output  1  IF/ID holds a real instruction
- ifid_instr  output  INSTR_W  IF/ID instruction
- ifid_pc_plus1  output  PC_W  address of fetched instruction + 1
- ifid_opcode  output  4  ifid_instr[15:12], to control decoder
- halted  output  1  fetch stopped on opcode 4'b1111

Behaviour:
- Reset values:
  - pc=RESET_PC, state=FETCH, hold_valid=0.
  - Outputs: imem_req=0, ifid_valid=0, ifid_instr=0, ifid_pc_plus1=0, halted=0.
  - imem_req first asserts the cycle after rst deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=pc. Address is held stable until imem_rdy.
  - HOLD: imem_req=0. One-entry hold buffer is full.
  - FLUSH: imem_req=0 for exactly one cycle; memory discards any outstanding fetch.
  - HALT: imem_req=0, halted=1.
- Priority each cycle: rst > redirect > all else.
- redirect=1 in any state:
  - pc<=redirect_pc, ifid_valid<=0, ifid_instr<=0, hold_valid<=0, state<=FLUSH.
  - Any imem_rdy/data arriving in that same cycle is discarded.
  - Redirect in HALT also exits HALT, because the halt was wrong-path.
- FETCH, imem_rdy=1, stall=0:
  - ifid_instr<=imem_data, ifid_pc_plus1<=pc+1, ifid_valid<=1, pc<=pc+1.
  - If imem_data[15:12]==4'b1111, then state<=HALT; otherwise stay in FETCH.
- FETCH, imem_rdy=1, stall=1:
  - IF/ID unchanged. hold_instr<=imem_data, hold_pc1<=pc+1, hold_valid<=1, pc<=pc+1, state<=HOLD.
- FETCH, imem_rdy=0, stall=0: bubble, ifid_valid<=0, ifid_instr<=0.
- FETCH, imem_rdy=0, stall=1: IF/ID unchanged, request continues.
- HOLD, stall=1: everything held.
- HOLD, stall=0:
  - IF/ID<=hold contents, ifid_valid<=1, hold_valid<=0.
  - state<=HALT if the held opcode is 4'b1111, else FETCH.
- FLUSH: next state is FETCH. IF/ID stays invalid.
- HALT: pc frozen. IF/ID follows stall: it holds while stall=1, otherwise it drains to a bubble.
- Arithmetic: pc+1 is modulo 2^PC_W, so 16'hFFFF wraps to 16'h0000. No other arithmetic.
- ifid_opcode is combinational from ifid_instr. Downstream gates on ifid_valid; an invalid entry always reads instr 0.
- Throughput: 1 instruction/cycle when imem_rdy is high every cycle and stall is low.
- Latency: data in IF/ID 1 cycle after the imem_rdy cycle.

Test Plan:
- Reset then back-to-back fetch: rst held 2 cycles, imem_rdy=1 constantly, data = 16'h0123, 16'h1456 → imem_addr 0,1,2 on successive cycles; ifid_opcode 4'h0 then 4'h1; ifid_pc_plus1 1 then 2.
- Slow memory: imem_rdy low for 3 cycles at pc=5 → imem_addr stays 5; ifid_valid=0 for those cycles; capture on the 4th cycle with ifid_pc_plus1=6.
- Stall with rdy: stall=1 while imem_rdy=1 returns 16'h8A01 at pc=3 → IF/ID unchanged and imem_req=0 for the stall cycles. On the stall release cycle ifid_instr=16'h8A01 and ifid_pc_plus1=4, with no lost or duplicated fetch.
- Redirect beats stall: redirect=1, stall=1, imem_rdy=1 with redirect_pc=16'h0040 → next cycle ifid_valid=0 and imem_req=0. The following cycle imem_addr=16'h0040.
- Halt and escape: fetch of 16'hF000 at pc=7 → ifid_opcode=4'hF, halted=1, imem_req=0, pc stays 8. A later redirect to 16'h0010 clears halted and resumes fetch at 16'h0010.
- Wrap: redirect_pc=16'hFFFF, fetch 16'h4000 → ifid_pc_plus1=16'h0000, next imem_addr=16'h0000. Also a reset mid-HOLD returns pc to RESET_PC and clears all valids.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with a multi-cycle instruction
// memory and feeds the IF/ID register, with a one-entry buffer for data that lands during a stall.
module if_stage #(
    parameter int PC_W = 16,
    parameter int INSTR_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc_plus1,
    output logic [3:0]         ifid_opcode,
    output logic               halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hF;

    state_t               state, state_nxt;
    logic [PC_W-1:0]      pc, pc_nxt, pc_inc;
    logic                 ifid_valid_nxt;
    logic [INSTR_W-1:0]   ifid_instr_nxt;
    logic [PC_W-1:0]      ifid_pc1_nxt;
    logic                 hold_valid, hold_valid_nxt;
    logic [INSTR_W-1:0]   hold_instr, hold_instr_nxt;
    logic [PC_W-1:0]      hold_pc1, hold_pc1_nxt;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4] == OP_HALT;
    endfunction

    assign pc_inc      = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign imem_req    = (state == FETCH) && !rst;
    assign imem_addr   = pc;
    assign ifid_opcode = ifid_instr[INSTR_W-1 -: 4];
    assign halted      = (state == HALT);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ifid_valid_nxt = ifid_valid;
        ifid_instr_nxt = ifid_instr;
        ifid_pc1_nxt   = ifid_pc_plus1;
        hold_valid_nxt = hold_valid;
        hold_instr_nxt = hold_instr;
        hold_pc1_nxt   = hold_pc1;

        // A redirect squashes everything, including data returning this same cycle.
        if (redirect) begin
            pc_nxt         = redirect_pc;
            ifid_valid_nxt = 1'b0;
            ifid_instr_nxt = '0;
            hold_valid_nxt = 1'b0;
            state_nxt      = FLUSH;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_rdy) begin
                        pc_nxt = pc_inc;
                        if (stall) begin
                            hold_instr_nxt = imem_data;
                            hold_pc1_nxt   = pc_inc;
                            hold_valid_nxt = 1'b1;
                            state_nxt      = HOLD;
                        end else begin
                            ifid_instr_nxt = imem_data;
                            ifid_pc1_nxt   = pc_inc;
                            ifid_valid_nxt = 1'b1;
                            state_nxt      = is_halt(imem_data) ? HALT : FETCH;
                        end
                    end else if (!stall) begin
                        ifid_valid_nxt = 1'b0;
                        ifid_instr_nxt = '0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_instr_nxt = hold_instr;
                        ifid_pc1_nxt   = hold_pc1;
                        ifid_valid_nxt = 1'b1;
                        hold_valid_nxt = 1'b0;
                        state_nxt      = is_halt(hold_instr) ? HALT : FETCH;
                    end
                end
                FLUSH: begin
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = '0;
                    state_nxt      = FETCH;
                end
                HALT: begin
                    if (!stall) begin
                        ifid_valid_nxt = 1'b0;
                        ifid_instr_nxt = '0;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            hold_valid    <= 1'b0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc_plus1 <= '0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            hold_valid    <= hold_valid_nxt;
            ifid_valid    <= ifid_valid_nxt;
            ifid_instr    <= ifid_instr_nxt;
            ifid_pc_plus1 <= ifid_pc1_nxt;
        end
    end

    // Hold buffer payload is qualified by hold_valid/state, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_instr <= hold_instr_nxt;
        hold_pc1   <= hold_pc1_nxt;
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then random
// stall/redirect/ready traffic checked every cycle against a behavioural model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus1;
    logic [3:0]  ifid_opcode;
    logic        halted;

    int total = 0;
    int bad = 0;
    bit rnd = 1'b0;
    bit started = 1'b0;

    // Behavioural model: architectural view of the fetch stage.
    logic [15:0] m_pc = 16'h0;
    logic        m_valid = 1'b0;
    logic [15:0] m_instr = 16'h0;
    logic [15:0] m_pc1 = 16'h0;
    logic        m_halt = 1'b0;
    logic        m_flush = 1'b0;
    logic [31:0] m_held[$];

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .ifid_valid(ifid_valid),
        .ifid_instr(ifid_instr), .ifid_pc_plus1(ifid_pc_plus1),
        .ifid_opcode(ifid_opcode), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_pc <= 16'h0; m_valid <= 1'b0; m_instr <= 16'h0; m_pc1 <= 16'h0;
            m_halt <= 1'b0; m_flush <= 1'b0; m_held.delete();
        end else if (redirect) begin
            m_pc <= redirect_pc; m_valid <= 1'b0; m_instr <= 16'h0;
            m_halt <= 1'b0; m_flush <= 1'b1; m_held.delete();
        end else if (m_flush) begin
            m_flush <= 1'b0;
        end else if (m_halt) begin
            if (!stall) begin m_valid <= 1'b0; m_instr <= 16'h0; end
        end else if (m_held.size() != 0) begin
            if (!stall) begin
                m_instr <= m_held[0][31:16];
                m_pc1   <= m_held[0][15:0];
                m_valid <= 1'b1;
                m_halt  <= (m_held[0][31:28] == 4'hF);
                void'(m_held.pop_front());
            end
        end else if (imem_rdy) begin
            if (stall) begin
                m_held.push_back({imem_data, m_pc + 16'd1});
            end else begin
                m_instr <= imem_data; m_pc1 <= m_pc + 16'd1; m_valid <= 1'b1;
                m_halt  <= (imem_data[15:12] == 4'hF);
            end
            m_pc <= m_pc + 16'd1;
        end else if (!stall) begin
            m_valid <= 1'b0; m_instr <= 16'h0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("req",    {31'b0, imem_req}, {31'b0, !rst && !m_halt && !m_flush && m_held.size() == 0});
            chk("addr",   {16'b0, imem_addr}, {16'b0, m_pc});
            chk("valid",  {31'b0, ifid_valid}, {31'b0, m_valid});
            chk("instr",  {16'b0, ifid_instr}, {16'b0, m_instr});
            chk("pc1",    {16'b0, ifid_pc_plus1}, {16'b0, m_pc1});
            chk("opcode", {28'b0, ifid_opcode}, {28'b0, m_instr[15:12]});
            chk("halted", {31'b0, halted}, {31'b0, m_halt});
            if (rnd && m_valid)
                chk("mem_content", {16'b0, ifid_instr}, {16'b0, mem(m_pc1 - 16'd1)});
        end
    end

    initial begin
        // Reset held two cycles, then back-to-back fetch.
        imem_rdy = 1'b1; imem_data = 16'h0123;
        cyc(); cyc();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_pc1", {16'b0, ifid_pc_plus1}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        rst = 1'b0; #1;
        chk("b2b_req0", {31'b0, imem_req}, 32'd1);
        chk("b2b_addr0", {16'b0, imem_addr}, 32'h0);
        cyc(); imem_data = 16'h1456;
        chk("b2b_op0", {28'b0, ifid_opcode}, 32'h0);
        chk("b2b_pc1_0", {16'b0, ifid_pc_plus1}, 32'h1);
        chk("b2b_addr1", {16'b0, imem_addr}, 32'h1);
        cyc();
        chk("b2b_op1", {28'b0, ifid_opcode}, 32'h1);
        chk("b2b_pc1_1", {16'b0, ifid_pc_plus1}, 32'h2);
        chk("b2b_addr2", {16'b0, imem_addr}, 32'h2);

        // Slow memory at pc=5.
        redirect = 1'b1; redirect_pc = 16'h0005; cyc();
        redirect = 1'b0; imem_rdy = 1'b0; cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("slow_addr", {16'b0, imem_addr}, 32'h5);
            chk("slow_valid", {31'b0, ifid_valid}, 32'd0);
        end
        imem_rdy = 1'b1; imem_data = 16'h2222; cyc();
        chk("slow_valid4", {31'b0, ifid_valid}, 32'd1);
        chk("slow_pc1", {16'b0, ifid_pc_plus1}, 32'h6);

        // Stall while data returns at pc=3.
        redirect = 1'b1; redirect_pc = 16'h0002; cyc();
        redirect = 1'b0; imem_rdy = 1'b0; cyc();
        imem_rdy = 1'b1; imem_data = 16'h7777; cyc();
        stall = 1'b1; imem_data = 16'h8A01; cyc();
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_instr", {16'b0, ifid_instr}, 32'h7777);
        imem_data = 16'h1111; cyc();
        chk("stall_req2", {31'b0, imem_req}, 32'd0);
        chk("stall_pc1", {16'b0, ifid_pc_plus1}, 32'h3);
        stall = 1'b0; cyc();
        chk("rel_instr", {16'b0, ifid_instr}, 32'h8A01);
        chk("rel_pc1", {16'b0, ifid_pc_plus1}, 32'h4);
        chk("rel_addr", {16'b0, imem_addr}, 32'h4);
        imem_data = 16'h2468; cyc();
        chk("next_instr", {16'b0, ifid_instr}, 32'h2468);
        chk("next_pc1", {16'b0, ifid_pc_plus1}, 32'h5);

        // Redirect beats stall.
        redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0040; imem_data = 16'h9999; cyc();
        chk("redir_valid", {31'b0, ifid_valid}, 32'd0);
        chk("redir_req", {31'b0, imem_req}, 32'd0);
        redirect = 1'b0; stall = 1'b0; cyc();
        chk("redir_addr", {16'b0, imem_addr}, 32'h0040);

        // Halt at pc=7 and escape by redirect.
        redirect = 1'b1; redirect_pc = 16'h0007; cyc();
        redirect = 1'b0; imem_rdy = 1'b0; cyc();
        imem_rdy = 1'b1; imem_data = 16'hF000; cyc();
        chk("halt_op", {28'b0, ifid_opcode}, 32'hF);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_req", {31'b0, imem_req}, 32'd0);
        chk("halt_addr", {16'b0, imem_addr}, 32'h8);
        imem_data = 16'h1234; stall = 1'b1; cyc();
        chk("halt_hold_op", {28'b0, ifid_opcode}, 32'hF);
        stall = 1'b0; cyc();
        chk("halt_drain", {31'b0, ifid_valid}, 32'd0);
        chk("halt_addr2", {16'b0, imem_addr}, 32'h8);
        redirect = 1'b1; redirect_pc = 16'h0010; cyc();
        chk("esc_halted", {31'b0, halted}, 32'd0);
        redirect = 1'b0; imem_data = 16'h3333; cyc();
        chk("esc_addr", {16'b0, imem_addr}, 32'h0010);
        chk("esc_req", {31'b0, imem_req}, 32'd1);
        cyc();
        chk("esc_pc1", {16'b0, ifid_pc_plus1}, 32'h0011);

        // PC wrap, then reset while holding.
        redirect = 1'b1; redirect_pc = 16'hFFFF; cyc();
        redirect = 1'b0; imem_rdy = 1'b0; cyc();
        chk("wrap_addr0", {16'b0, imem_addr}, 32'hFFFF);
        imem_rdy = 1'b1; imem_data = 16'h4000; cyc();
        chk("wrap_pc1", {16'b0, ifid_pc_plus1}, 32'h0000);
        chk("wrap_addr", {16'b0, imem_addr}, 32'h0000);
        stall = 1'b1; imem_data = 16'h5555; cyc();
        chk("hold_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b1; stall = 1'b0; cyc();
        chk("mrst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("mrst_instr", {16'b0, ifid_instr}, 32'h0);
        chk("mrst_addr", {16'b0, imem_addr}, 32'h0);
        rst = 1'b0; imem_rdy = 1'b0; #1;
        chk("mrst_req", {31'b0, imem_req}, 32'd1);

        // Random traffic.
        rnd = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom % 300) == 0;
            stall       = ($urandom % 4) == 0;
            redirect    = ($urandom % 16) == 0;
            redirect_pc = (($urandom % 8) == 0) ? 16'hFFFF : 16'($urandom);
            imem_rdy    = ($urandom % 3) != 0;
            imem_data   = mem(m_pc);
            cyc();
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; imem_rdy = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
